// File: rtl/button_pkg.sv
// ============================================================================
// Module  : button_pkg
// Purpose : Shared constants, repeat-state encoding and width helper for the
//           button conditioner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package button_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed to represent values 0..value-1; used for counter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
// Module  : button_channel
// Purpose : One button channel: 2-flop synchronizer, debounce counter, edge
//           pulses and hold-to-repeat state machine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_channel
  import button_pkg::*;
#(
  parameter int DEB_CYCLES    = 250000,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_signal,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_pulse
);

  localparam int DEB_W   = clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] c_DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] c_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] c_RPT_SAT  = {RPT_W{1'b1}};

  logic             r_meta;
  logic             r_sync;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_pulse;
  rpt_state_t       r_state;
  logic [RPT_W-1:0] r_rcnt;

  logic             w_differ;
  logic             w_settle;
  logic             w_rise_evt;
  logic             w_fall_evt;
  logic             w_edge_evt;
  logic             w_rpt_evt;
  logic [RPT_W-1:0] w_rcnt_inc;
  logic [RPT_W-1:0] w_rcnt_nxt;
  rpt_state_t       w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_signal;
      r_sync <= r_meta;
    end
  end

  // The level only flips on the cycle the counter has seen DEB_CYCLES
  // consecutive mismatches; any agreement in between restarts the count.
  assign w_differ   = (r_sync != r_level);
  assign w_settle   = w_differ && (r_deb_cnt == c_DEB_LAST);
  assign w_rise_evt = w_settle && r_sync;
  assign w_fall_evt = w_settle && !r_sync;

  always_comb begin
    w_edge_evt = w_rise_evt;
    case (EDGE_MODE)
      EDGE_FALL: w_edge_evt = w_fall_evt;
      EDGE_BOTH: w_edge_evt = w_rise_evt | w_fall_evt;
      default:   w_edge_evt = w_rise_evt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      if (!w_differ || w_settle) begin
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
      if (w_settle) begin
        r_level <= r_sync;
      end
      r_rise  <= w_rise_evt;
      r_fall  <= w_fall_evt;
      r_pulse <= w_edge_evt | w_rpt_evt;
    end
  end

  assign w_rcnt_inc = (r_rcnt == c_RPT_SAT) ? r_rcnt : (r_rcnt + RPT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RPT_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // A release always wins over a due repeat so no pulse leaks out on the
  // cycle the button is seen released.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rpt_evt   = 1'b0;
    case (r_state)
      RPT_IDLE: begin
        if (w_rise_evt && (REPEAT_DELAY > 0)) begin
          w_state_nxt = RPT_HOLD;
          w_rcnt_nxt  = '0;
        end
      end
      RPT_HOLD: begin
        if (w_fall_evt) begin
          w_state_nxt = RPT_IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == c_DLY_LAST) begin
          w_state_nxt = RPT_REPEAT;
          w_rcnt_nxt  = '0;
          w_rpt_evt   = 1'b1;
        end else begin
          w_rcnt_nxt  = w_rcnt_inc;
        end
      end
      RPT_REPEAT: begin
        if (w_fall_evt) begin
          w_state_nxt = RPT_IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == c_PER_LAST) begin
          w_rcnt_nxt  = '0;
          w_rpt_evt   = 1'b1;
        end else begin
          w_rcnt_nxt  = w_rcnt_inc;
        end
      end
      default: begin
        w_state_nxt = RPT_IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module  : button_conditioner
// Purpose : N_CH independent debounced button channels with edge pulses and
//           optional auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 250000,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] signal,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .EDGE_MODE     (EDGE_MODE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_signal (signal[g]),
      .o_level  (level[g]),
      .o_rise   (rise[g]),
      .o_fall   (fall[g]),
      .o_pulse  (pulse[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module  : tb_button_conditioner
// Purpose : Self-checking bench for button_conditioner (2 channels, short
//           debounce, rising-edge mode, auto-repeat 8/3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int N_CH          = 2;
  localparam int DEB_CYCLES    = 4;
  localparam int EDGE_MODE     = 0;
  localparam int REPEAT_DELAY  = 8;
  localparam int REPEAT_PERIOD = 3;
  localparam int NEVER         = 100000;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] signal;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] pulse;

  int n_checks;
  int n_errors;

  logic [7:0] sb_q[$];
  logic [7:0] got;
  logic [7:0] exp_v;

  button_conditioner #(
    .N_CH          (N_CH),
    .DEB_CYCLES    (DEB_CYCLES),
    .EDGE_MODE     (EDGE_MODE),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .signal (signal),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .pulse  (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline of one clean channel: new input first sampled on edge p, so
  // outputs change after edge p+5; repeats at +8 then every 3 while held.
  function automatic logic [3:0] ref_clean(input int k, input int p, input int r);
    int re;
    int fe;
    logic lv;
    logic rs;
    logic fl;
    logic pl;
    re = p + DEB_CYCLES + 1;
    fe = r + DEB_CYCLES + 1;
    lv = (k >= re) && (k < fe);
    rs = (k == re);
    fl = (k == fe);
    pl = rs || ((k < fe) && (k >= re + REPEAT_DELAY) &&
                (((k - re - REPEAT_DELAY) % REPEAT_PERIOD) == 0));
    return {lv, rs, fl, pl};
  endfunction

  function automatic logic [7:0] pack2(input logic [3:0] c1, input logic [3:0] c0);
    return {c1[3], c0[3], c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    signal = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({level, rise, fall, pulse} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_hold got=%b exp=%b", {level, rise, fall, pulse}, 8'h00);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      sb_q.push_back(8'h00);
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      signal = {1'b0, (k <= 6)};
      sb_q.push_back(pack2(4'h0, ref_clean(k, 1, 7)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL clean_press cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      signal = {1'b0, ((k <= 3) || (k >= 6 && k <= 8))};
      sb_q.push_back(8'h00);
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_auto_repeat();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      signal = {1'b0, (k <= 30)};
      sb_q.push_back(pack2(4'h0, ref_clean(k, 1, 31)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL auto_repeat cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  // Bounce segments are 2 cycles, shorter than the debounce window, so the
  // channel looks like a clean release starting at the final low (cycle 17).
  task automatic test_bounce_release();
    logic s;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k <= 8)       s = 1'b1;
      else if (k <= 18) s = (((k - 9) / 2) % 2) == 1;
      else              s = 1'b0;
      signal = {1'b0, s};
      sb_q.push_back(pack2(4'h0, ref_clean(k, 1, 17)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL bounce_release cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      signal = {(k <= 6), (k <= 9)};
      sb_q.push_back(pack2(ref_clean(k, 1, 7), ref_clean(k, 1, 10)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL simultaneous cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      signal = 2'b01;
      sb_q.push_back(pack2(4'h0, ref_clean(k, 1, NEVER)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, rise, fall, pulse} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", {level, rise, fall, pulse}, 8'h00);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({level, rise, fall, pulse} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid_hold got=%b exp=%b", {level, rise, fall, pulse}, 8'h00);
    end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      signal = {1'b0, (k <= 10)};
      sb_q.push_back(pack2(4'h0, ref_clean(k, 1, 11)));
      @(posedge clk); #1;
      got   = {level, rise, fall, pulse};
      exp_v = sb_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", k, got, exp_v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    signal   = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_bounce_release();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 250000: required input stability in clk cycles, range 1 or more.
REQ-003 The block SHALL have parameter EDGE_MODE, default 0: pulse source, where 0 = rising, 1 = falling, 2 = both.
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 0: hold cycles after the press pulse before the first repeat pulse, where 0 disables repeat.
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 1: cycles between repeat pulses, range 1 or more.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port signal, input, N_CH bits: raw asynchronous button levels, where 1 = pressed.
REQ-009 The block SHALL have port level, output, N_CH bits: debounced stable level per channel.
REQ-010 The block SHALL have port rise, output, N_CH bits: one-cycle pulse when level goes 0 to 1.
REQ-011 The block SHALL have port fall, output, N_CH bits: one-cycle pulse when level goes 1 to 0.
REQ-012 The block SHALL have port pulse, output, N_CH bits: the EDGE_MODE-selected edge pulse ORed with auto-repeat pulses.

Function
REQ-013 Each signal bit SHALL pass through a 2-flop synchronizer; only the second flop output, sync, feeds further logic.
REQ-014 Each channel SHALL have a debounce counter of width clog2(DEB_CYCLES+1) that clears whenever sync equals level.
REQ-015 While sync differs from level, the counter SHALL increment by 1 per cycle.
REQ-016 When the counter equals DEB_CYCLES-1 and sync still differs, on that edge level SHALL take sync, the counter SHALL clear, and rise or fall SHALL assert.
REQ-017 A single glitch shorter than DEB_CYCLES cycles, measured at sync, SHALL clear the counter and produce no level change and no pulse.
REQ-018 Latency SHALL be exact: the input must be stable for DEB_CYCLES synchronized cycles, and level, rise, fall and pulse are registered, so level changes DEB_CYCLES+2 posedges after the first posedge sampling the new value.
REQ-019 rise, fall and pulse SHALL each be high for exactly one cycle per event; rise and fall SHALL never be high together on one channel.
REQ-020 Each channel SHALL implement a repeat state machine with states IDLE, HOLD and REPEAT.
REQ-021 The repeat state machine SHALL leave IDLE for HOLD on rise when REPEAT_DELAY > 0, loading a repeat counter with 0.
REQ-022 HOLD SHALL count to REPEAT_DELAY-1 and then enter REPEAT, asserting pulse on the entry cycle and clearing the counter.
REQ-023 REPEAT SHALL assert pulse every REPEAT_PERIOD cycles.
REQ-024 A fall in HOLD or REPEAT SHALL return the state machine to IDLE on that edge with no repeat pulse in that cycle.
REQ-025 When EDGE_MODE is 1 or 2, that same fall cycle SHALL still assert the fall pulse.
REQ-026 The repeat counter width SHALL be clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) and SHALL saturate, never wrapping.
REQ-027 When an edge pulse and a repeat pulse coincide, the block SHALL emit one pulse, not two.
REQ-028 Channels SHALL be fully independent, so simultaneous events on multiple channels produce simultaneous independent outputs.
REQ-029 An invalid EDGE_MODE value of 3 SHALL behave as mode 0.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously clear the synchronizer flops, counters, level, rise, fall and pulse to 0 and set the state machines to IDLE.
REQ-031 A button held through reset SHALL be treated as a new press after release of reset: it produces rise DEB_CYCLES+2 cycles later.
REQ-032 Reset asserted mid-debounce or mid-repeat SHALL abort without emitting any pulse.
REQ-033 Reset release SHALL be synchronous to clk, with no output change on the release edge itself.

Structure
REQ-034 Package button_pkg SHALL hold the EDGE_MODE constants EDGE_RISE=0, EDGE_FALL=1 and EDGE_BOTH=2, the repeat state encoding and a clog2 helper.
REQ-035 Sub-module button_channel SHALL implement the synchronizer, debounce, edge and repeat logic for one channel.
REQ-036 button_conditioner SHALL instantiate button_channel N_CH times and contain no other logic.

Verification
Bench parameters: N_CH=2, DEB_CYCLES=4, EDGE_MODE=0, REPEAT_DELAY=8, REPEAT_PERIOD=3.
REQ-037 Clean press: signal[0] held at 1 -> level[0], rise[0] and pulse[0] assert exactly 6 posedges after the first sampling edge; rise[0] lasts 1 cycle; channel 1 stays 0.
REQ-038 Glitch: signal[0] high for 3 cycles, low, then high for 3 cycles -> level, rise and pulse stay 0 throughout.
REQ-039 Auto-repeat: hold signal[0] high for 30 cycles -> pulses at cycles t0, t0+8, t0+11, t0+14 and so on; release -> fall is immediate after debounce, with no further pulse.
REQ-040 Bounce on release: press, then toggle signal[0] every 2 cycles for 10 cycles, then hold low -> exactly one fall, 6 cycles after the final low.
REQ-041 Simultaneous channels: signal equals 2'b11 in the same cycle -> rise equals 2'b11 on the same cycle; release channel 1 only -> fall equals 2'b10.
REQ-042 Reset mid-operation: assert rst_n low during REPEAT -> all outputs 0 asynchronously; release rst_n with signal still high -> rise 6 cycles later.
